// File: rtl/fetch_pkg.sv
// Purpose : shared types and default sizes for the fetch stage.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package fetch_pkg;

   localparam int ADDR_W = 8;   // default instruction address width
   localparam int CNT_W  = 16;  // default cycle counter width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Purpose : width-parameterised up-counter with synchronous clear that sticks at all-ones.
// Latency : one edge from clr/en to count.
// Backpr. : none; en simply gates the increment.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, forces count to 0
//   clr   - synchronous clear, wins over en
//   en    - increment request, ignored once the counter is saturated
//   count - registered counter value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Purpose : program counter and fetch sequencer (IDLE/RUN/DONE) driving the instruction ROM address.
// Latency : Start/branch/increment visible on InstAddress one edge later; outputs are registered or state-decoded.
// Backpr. : Stall freezes PC and state for the cycle; Start is ignored while running.
//
// Optional feature macro: FETCH_CYCLE_COUNT_EN (RUN-cycle counter on CycleCount;
// when undefined CycleCount is tied to 0 and no counter flops exist).
//
// Ports:
//   Clk, Reset            - clock, asynchronous active-high reset
//   Start, StartAddr      - launch request (accepted in IDLE/DONE) and first fetch address
//   Stall, Halt           - freeze this cycle / current instruction halts the program
//   BranchEn, BranchTarget- taken branch and its absolute target
//   InstAddress           - registered PC to the ROM
//   Running, Done         - state decodes for RUN and DONE
//   CycleCount            - edges spent in RUN since the last start (saturating)
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int L  = ADDR_W,
   parameter int CW = CNT_W
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [L-1:0]  StartAddr,
   input  logic          Stall,
   input  logic          Halt,
   input  logic          BranchEn,
   input  logic [L-1:0]  BranchTarget,
   output logic [L-1:0]  InstAddress,
   output logic          Running,
   output logic          Done,
   output logic [CW-1:0] CycleCount
);

   fetch_state_t state_q;
   fetch_state_t state_d;
   logic [L-1:0] pc_q;
   logic [L-1:0] pc_d;
   logic         running_o;
   logic         done_o;

   // State and PC registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state and next PC. In RUN the priority is Stall > Halt > BranchEn > increment;
   // on Halt the PC stays on the halt instruction.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (Start) begin
               pc_d    = StartAddr;
               state_d = RUN;
            end
         end
         RUN: begin
            if (Stall) begin
               // frozen for this cycle
            end else if (Halt) begin
               state_d = DONE;
            end else if (BranchEn) begin
               pc_d = BranchTarget;
            end else begin
               pc_d = pc_q + L'(1);   // wraps silently at 2**L-1
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
         end
      endcase
   end

   // Status outputs are pure state decodes.
   always_comb begin
      running_o = 1'b0;
      done_o    = 1'b0;
      unique case (state_q)
         RUN:     running_o = 1'b1;
         DONE:    done_o    = 1'b1;
         default: ;
      endcase
   end

   assign InstAddress = pc_q;
   assign Running     = running_o;
   assign Done        = done_o;

`ifdef FETCH_CYCLE_COUNT_EN
   logic start_acc;

   // Start is only accepted outside RUN; that same edge zeroes the count.
   assign start_acc = Start && (state_q != RUN);

   sat_counter #(.W(CW)) u_cycle_cnt (
      .clk   (Clk),
      .rst   (Reset),
      .clr   (start_acc),
      .en    (state_q == RUN),
      .count (CycleCount)
   );
`else
   assign CycleCount = '0;
`endif

endmodule
